io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning output FIFO entries (power of two, 2..64).
REQ-002 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port CS  in  1  chip select from CPU address decoder; access valid only when high.
REQ-005 SHALL have port WR_RD  in  1  1 = write, 0 = read.
REQ-006 SHALL have port ADDR  in  32  byte address; only ADDR[4:2] decoded.
REQ-007 SHALL have port Data_BUS_WRITE  in  32  write data from CPU.
REQ-008 SHALL have port Data_BUS_READ  out  32  read data to CPU.
REQ-009 SHALL have port out_data  out  32  FIFO head word.
REQ-010 SHALL have port out_valid  out  1  FIFO non-empty.
REQ-011 SHALL have port out_ready  in  1  downstream accepts head.
REQ-012 SHALL have port irq  out  1  timer interrupt, level.

Function
REQ-013 SHALL be zero-wait-state: Data_BUS_READ combinational from current state when CS=1, WR_RD=0; 0 otherwise.
REQ-014 SHALL commit writes on the rising edge where CS=1, WR_RD=1.
REQ-015 SHALL decode ADDR[4:2]: 0 TXDATA, 1 STATUS, 2 TIMER_LOAD, 3 TIMER_COUNT, 4 CTRL; others read 0, writes ignored.
REQ-016 SHALL push Data_BUS_WRITE into FIFO on TXDATA write; TXDATA reads 0.
REQ-017 SHALL accept push when not full, or when full with a pop in the same cycle (count unchanged).
REQ-018 SHALL drop a push to a full FIFO without pop and set STATUS.ovf (sticky).
REQ-019 SHALL pop on out_valid & out_ready; out_valid = !empty; out_data = head, 0 when empty.
REQ-020 SHALL make a pushed word visible on out_valid/out_data one cycle after the write edge; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL provide STATUS read: [0] empty, [1] full, [2] ovf, [3] expired, [15:8] count, rest 0.
REQ-022 SHALL clear STATUS bits 2,3 by write-1-to-clear; a same-cycle set wins over clear.
REQ-023 SHALL provide CTRL[0] timer_en, [1] irq_en, [2] auto_reload, read/write; other bits 0.
REQ-024 SHALL, on TIMER_LOAD write, store load value and set count = value; this write overrides decrement/reload and suppresses expiry that cycle.
REQ-025 SHALL decrement count each cycle when timer_en=1 and count!=0.
REQ-026 SHALL, when count decrements 1->0, set expired; if auto_reload, load count = load value on that same edge instead of 0.
REQ-027 SHALL hold count at 0 when enabled without auto_reload; TIMER_COUNT reads current count.
REQ-028 SHALL drive irq = expired & irq_en.

Reset
REQ-029 SHALL, on Rst high at an edge, empty FIFO, zero pointers, ovf, expired, CTRL, load, count; outputs: out_valid=0, out_data=0, irq=0.
REQ-030 SHALL let Rst override any same-cycle bus write or pop.

Configuration
REQ-031 SHALL compile the timer in only when IO_RESP_TIMER_EN is defined.
REQ-032 SHALL, without IO_RESP_TIMER_EN, read TIMER_LOAD/TIMER_COUNT as 0, ignore their writes, tie STATUS[3], CTRL[0], CTRL[2] and irq to 0; FIFO unaffected.

Structure
REQ-033 SHALL place register offsets, STATUS and CTRL bit positions in shared package io_resp_pkg.
REQ-034 SHALL implement the FIFO as sub-module io_resp_fifo (push, pop, full, empty, count).

Verification
REQ-035 SHALL cover: write 0x000000AA to TXDATA with out_ready=0 -> next cycle out_valid=1, out_data=0xAA, STATUS read 0x00000100.
REQ-036 SHALL cover: 9 TXDATA writes with out_ready=0 (depth 8) -> STATUS=0x00000806 (full, ovf), 9th word absent; W1C 0x4 clears ovf.
REQ-037 SHALL cover: full FIFO, TXDATA write with out_ready=1 -> count stays 8, new word at tail, ovf stays 0.
REQ-038 SHALL cover: TIMER_LOAD=3, CTRL=0x3 -> expired and irq high 3 cycles after CTRL write edge; count 0; W1C 0x8 drops irq.
REQ-039 SHALL cover: TIMER_LOAD=2, CTRL=0x7 -> expired set, TIMER_COUNT reads 2 after expiry, irq persists until cleared.
REQ-040 SHALL cover: Rst pulse mid-stream with 4 queued words and running timer -> next cycle out_valid=0, irq=0, all registers read 0.

Source files
------------

// File: rtl/io_resp_pkg.sv
// Shared register map and bit positions for the io_responder CPU slave.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package io_resp_pkg;

    typedef logic [31:0] word_t;

    // Register select values taken from ADDR[4:2]
    localparam logic [2:0] REG_TXDATA      = 3'd0;
    localparam logic [2:0] REG_STATUS      = 3'd1;
    localparam logic [2:0] REG_TIMER_LOAD  = 3'd2;
    localparam logic [2:0] REG_TIMER_COUNT = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;

    // STATUS bit positions; the FIFO count occupies [15:8]
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_EXPIRED   = 3;
    localparam int ST_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_TIMER_EN    = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;

    // Assemble the STATUS read word from its fields
    function automatic word_t pack_status(input logic empty, input logic full,
                                          input logic ovf, input logic expired,
                                          input logic [7:0] count);
        word_t w;
        w                            = '0;
        w[ST_EMPTY]                  = empty;
        w[ST_FULL]                   = full;
        w[ST_OVF]                    = ovf;
        w[ST_EXPIRED]                = expired;
        w[ST_COUNT_LSB +: 8]         = count;
        return w;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU bus plus output stream bundle for io_responder.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the stream sink throttles out_valid/out_data.
interface io_responder_if;
    import io_resp_pkg::*;

    logic  CS;
    logic  WR_RD;
    word_t ADDR;
    word_t Data_BUS_WRITE;
    word_t Data_BUS_READ;
    word_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  irq;

    // CPU / stream-sink side
    modport master (
        output CS, WR_RD, ADDR, Data_BUS_WRITE, out_ready,
        input  Data_BUS_READ, out_data, out_valid, irq
    );

    // io_responder side
    modport slave (
        input  CS, WR_RD, ADDR, Data_BUS_WRITE, out_ready,
        output Data_BUS_READ, out_data, out_valid, irq
    );

endinterface

// File: rtl/io_resp_fifo.sv
// Synchronous word FIFO with simultaneous push/pop, head shown combinationally.
// Latency: a pushed word is at the head one cycle after its push edge (if FIFO was empty).
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module io_resp_fifo
    import io_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  word_t                  push_dat,
    input  logic                   pop,
    output word_t                  head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop_ok   = pop & ~empty;
    // A full FIFO still takes a word when the head leaves on the same edge
    assign push_ok  = push & (~full | pop_ok);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks the head
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/io_responder.sv
// Zero-wait-state CPU slave: TX FIFO to a valid/ready stream, STATUS/CTRL, optional timer (IO_RESP_TIMER_EN).
// Latency: reads combinational; writes commit on the CS&WR_RD edge; pushed word visible next cycle.
// Backpressure: out_ready stalls the FIFO; TXDATA writes to a full FIFO without a pop are dropped and flag ovf.
module io_responder
    import io_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic          CLK,
    input  logic          Rst,
    io_responder_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]    reg_sel;
    logic          wr_en;
    logic          rd_en;
    logic          tx_wr;
    logic          status_wr;
    logic          ctrl_wr;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    word_t         fifo_head;
    logic          ovf;
    logic          ctrl_irq_en;
    word_t         rd_word;
    logic          unused_addr_bits;

    assign reg_sel          = bus.ADDR[4:2];
    assign unused_addr_bits = ^{bus.ADDR[31:5], bus.ADDR[1:0]};
    assign wr_en            = bus.CS &  bus.WR_RD;
    assign rd_en            = bus.CS & ~bus.WR_RD;
    assign tx_wr            = wr_en & (reg_sel == REG_TXDATA);
    assign status_wr        = wr_en & (reg_sel == REG_STATUS);
    assign ctrl_wr          = wr_en & (reg_sel == REG_CTRL);
    assign pop              = ~fifo_empty & bus.out_ready;

    io_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (CLK),
        .rst      (Rst),
        .push     (tx_wr),
        .push_dat (bus.Data_BUS_WRITE),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Sticky overflow: set by a dropped push, cleared by writing 1 to STATUS[2]
    always_ff @(posedge CLK) begin
        if (Rst)                                          ovf <= 1'b0;
        else if (tx_wr && fifo_full && !pop)              ovf <= 1'b1;
        else if (status_wr && bus.Data_BUS_WRITE[ST_OVF]) ovf <= 1'b0;
    end

    // Interrupt enable is always present, even without the timer
    always_ff @(posedge CLK) begin
        if (Rst)          ctrl_irq_en <= 1'b0;
        else if (ctrl_wr) ctrl_irq_en <= bus.Data_BUS_WRITE[CTRL_IRQ_EN];
    end

`ifdef IO_RESP_TIMER_EN
    logic  ctrl_timer_en;
    logic  ctrl_auto_reload;
    logic  load_wr;
    logic  expire_evt;
    logic  expired;
    word_t tmr_load;
    word_t tmr_count;

    assign load_wr    = wr_en & (reg_sel == REG_TIMER_LOAD);
    // A TIMER_LOAD write on the same edge pre-empts the 1->0 step
    assign expire_evt = ctrl_timer_en & (tmr_count == 32'd1) & ~load_wr;

    // Timer control bits
    always_ff @(posedge CLK) begin
        if (Rst) begin
            ctrl_timer_en    <= 1'b0;
            ctrl_auto_reload <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_timer_en    <= bus.Data_BUS_WRITE[CTRL_TIMER_EN];
            ctrl_auto_reload <= bus.Data_BUS_WRITE[CTRL_AUTO_RELOAD];
        end
    end

    // Down-counter: load write wins, else count down to 0 (or reload on expiry)
    always_ff @(posedge CLK) begin
        if (Rst) begin
            tmr_load  <= '0;
            tmr_count <= '0;
        end else if (load_wr) begin
            tmr_load  <= bus.Data_BUS_WRITE;
            tmr_count <= bus.Data_BUS_WRITE;
        end else if (ctrl_timer_en && tmr_count != '0) begin
            if (tmr_count == 32'd1) tmr_count <= ctrl_auto_reload ? tmr_load : '0;
            else                    tmr_count <= tmr_count - 32'd1;
        end
    end

    // Sticky expiry flag; a same-edge expiry beats the write-1-to-clear
    always_ff @(posedge CLK) begin
        if (Rst)                                              expired <= 1'b0;
        else if (expire_evt)                                  expired <= 1'b1;
        else if (status_wr && bus.Data_BUS_WRITE[ST_EXPIRED]) expired <= 1'b0;
    end
`else
    logic  ctrl_timer_en;
    logic  ctrl_auto_reload;
    logic  expired;
    word_t tmr_load;
    word_t tmr_count;

    assign ctrl_timer_en    = 1'b0;
    assign ctrl_auto_reload = 1'b0;
    assign expired          = 1'b0;
    assign tmr_load         = '0;
    assign tmr_count        = '0;
`endif

    // Register read mux; TXDATA and unmapped offsets read as zero
    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_STATUS:      rd_word = pack_status(fifo_empty, fifo_full, ovf, expired,
                                                   8'(fifo_count));
            REG_TIMER_LOAD:  rd_word = tmr_load;
            REG_TIMER_COUNT: rd_word = tmr_count;
            REG_CTRL: begin
                rd_word[CTRL_TIMER_EN]    = ctrl_timer_en;
                rd_word[CTRL_IRQ_EN]      = ctrl_irq_en;
                rd_word[CTRL_AUTO_RELOAD] = ctrl_auto_reload;
            end
            default:         rd_word = '0;
        endcase
    end

    assign bus.Data_BUS_READ = rd_en ? rd_word : '0;
    assign bus.out_valid     = ~fifo_empty;
    assign bus.out_data      = fifo_head;
    assign bus.irq           = expired & ctrl_irq_en;

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (FIFO_DEPTH = 8).
// Latency: inputs driven 1ns after posedge; outputs sampled 1-2ns after posedge.
// Backpressure: out_ready driven directly by the bench to hold or drain the FIFO.
module tb_io_responder;

    localparam logic [31:0] A_TX   = 32'h00;
    localparam logic [31:0] A_ST   = 32'h04;
    localparam logic [31:0] A_LD   = 32'h08;
    localparam logic [31:0] A_CNT  = 32'h0C;
    localparam logic [31:0] A_CTRL = 32'h10;
`ifdef IO_RESP_TIMER_EN
    localparam logic [31:0] CTRL_RB = 32'h7;
    localparam logic [31:0] EXP_BIT = 32'h8;
`else
    localparam logic [31:0] CTRL_RB = 32'h2;
    localparam logic [31:0] EXP_BIT = 32'h0;
`endif

    logic CLK = 1'b0;
    logic Rst;
    int   n_checks = 0;
    int   n_errors = 0;

    io_responder_if bus();

    io_responder #(.FIFO_DEPTH(8)) dut (
        .CLK (CLK),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.CS             = 1'b1;
        bus.WR_RD          = 1'b1;
        bus.ADDR           = a;
        bus.Data_BUS_WRITE = d;
        tick();
        bus.CS             = 1'b0;
        bus.WR_RD          = 1'b0;
        bus.Data_BUS_WRITE = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.CS    = 1'b1;
        bus.WR_RD = 1'b0;
        bus.ADDR  = a;
        #1;
        d         = bus.Data_BUS_READ;
        bus.CS    = 1'b0;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_val(tag, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst                = 1'b1;
        bus.CS             = 1'b0;
        bus.WR_RD          = 1'b0;
        bus.ADDR           = '0;
        bus.Data_BUS_WRITE = '0;
        bus.out_ready      = 1'b0;
        tick();
        tick();
        Rst = 1'b0;

        // Reset state: only the empty flag is set
        check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_val("rst_out_data",  bus.out_data,       32'h0);
        check_val("rst_irq",       32'(bus.irq),       32'h0);
        check_reg("rst_status",    A_ST,               32'h0000_0001);
        check_reg("rst_ctrl",      A_CTRL,             32'h0);

        // Single word, held by out_ready=0
        bus_write(A_TX, 32'h0000_00AA);
        check_val("one_out_valid", 32'(bus.out_valid), 32'h1);
        check_val("one_out_data",  bus.out_data,       32'h0000_00AA);
        check_reg("one_status",    A_ST,               32'h0000_0100);
        check_reg("txdata_read",   A_TX,               32'h0);
        bus.out_ready = 1'b1;
        tick();
        check_val("one_drained", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // Read port is zero unless CS=1 and WR_RD=0
        bus_write(A_TX, 32'h0000_0055);
        bus.ADDR = A_ST;
        bus.CS = 1'b0; bus.WR_RD = 1'b0; #1;
        check_val("rd_no_cs", bus.Data_BUS_READ, 32'h0);
        bus.CS = 1'b1; bus.WR_RD = 1'b1; #1;
        check_val("rd_during_wr", bus.Data_BUS_READ, 32'h0);
        bus.CS = 1'b0; bus.WR_RD = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Overflow: nine writes into depth 8
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + 32'(i));
        check_reg("ovf_status", A_ST, 32'h0000_0806);
        check_val("ovf_head",   bus.out_data, 32'h10);
        bus_write(A_ST, 32'h4);
        check_reg("ovf_w1c",    A_ST, 32'h0000_0802);

        // Write to full FIFO while popping: count stays 8, no overflow
        bus.out_ready = 1'b1;
        bus_write(A_TX, 32'h0000_BEEF);
        check_reg("full_pushpop_status", A_ST, 32'h0000_0802);
        for (int i = 1; i < 8; i++) begin
            check_val($sformatf("drain_%0d", i), bus.out_data, 32'h10 + 32'(i));
            tick();
        end
        check_val("drain_tail", bus.out_data, 32'h0000_BEEF);
        tick();
        check_val("drain_empty", 32'(bus.out_valid), 32'h0);
        check_reg("drain_status", A_ST, 32'h0000_0001);
        bus.out_ready = 1'b0;

        // Only ADDR[4:2] is decoded; 5..7 are unmapped
        bus_write(32'h14, 32'hFFFF_FFFF);
        bus_write(32'h1C, 32'hFFFF_FFFF);
        check_reg("unmapped_5", 32'h14, 32'h0);
        check_reg("unmapped_6", 32'h18, 32'h0);
        check_reg("unmapped_7", 32'h1C, 32'h0);
        check_reg("unmapped_status", A_ST, 32'h0000_0001);
        bus_write(32'h20, 32'h77);
        check_val("alias_tx_data", bus.out_data, 32'h77);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // CTRL readback masks unimplemented bits
        bus_write(A_CTRL, 32'hFFFF_FFFF);
        check_reg("ctrl_rb", A_CTRL, CTRL_RB);
        bus_write(A_CTRL, 32'h0);
        check_reg("ctrl_clr", A_CTRL, 32'h0);

`ifdef IO_RESP_TIMER_EN
        // One-shot: load 3, enable with irq -> expiry 3 edges after the CTRL edge
        bus_write(A_LD, 32'd3);
        check_reg("tmr_load_rb", A_LD, 32'd3);
        bus_write(A_CTRL, 32'h3);
        check_reg("tmr_e0", A_CNT, 32'd3);
        tick();
        check_reg("tmr_e1", A_CNT, 32'd2);
        tick();
        check_reg("tmr_e2", A_CNT, 32'd1);
        check_val("tmr_e2_irq", 32'(bus.irq), 32'h0);
        tick();
        check_val("tmr_e3_irq", 32'(bus.irq), 32'h1);
        check_reg("tmr_e3_status", A_ST, 32'h0000_0009);
        check_reg("tmr_e3_count", A_CNT, 32'd0);
        tick();
        check_reg("tmr_hold0", A_CNT, 32'd0);
        bus_write(A_ST, 32'h8);
        check_val("tmr_w1c_irq", 32'(bus.irq), 32'h0);
        check_reg("tmr_w1c_status", A_ST, 32'h0000_0001);

        // Auto-reload: load 2, CTRL=7
        bus_write(A_CTRL, 32'h0);
        bus_write(A_LD, 32'd2);
        bus_write(A_CTRL, 32'h7);
        check_reg("ar_e0", A_CNT, 32'd2);
        tick();
        check_reg("ar_e1", A_CNT, 32'd1);
        check_val("ar_e1_irq", 32'(bus.irq), 32'h0);
        tick();
        check_reg("ar_e2_count", A_CNT, 32'd2);
        check_val("ar_e2_irq", 32'(bus.irq), 32'h1);
        tick();
        check_val("ar_e3_irq", 32'(bus.irq), 32'h1);
        tick();
        check_reg("ar_e4_count", A_CNT, 32'd2);
        bus_write(A_ST, 32'h8);
        check_val("ar_w1c_irq", 32'(bus.irq), 32'h0);
        check_reg("ar_w1c_count", A_CNT, 32'd1);
        bus_write(A_ST, 32'h8);
        check_val("ar_set_wins", 32'(bus.irq), 32'h1);
        bus_write(A_LD, 32'd1);
`else
        // Timer absent: its registers read 0 and irq never rises
        bus_write(A_LD, 32'd3);
        check_reg("notmr_load", A_LD, 32'h0);
        check_reg("notmr_count", A_CNT, 32'h0);
        bus_write(A_CTRL, 32'h7);
        check_reg("notmr_ctrl", A_CTRL, 32'h2);
        for (int i = 0; i < 4; i++) tick();
        check_val("notmr_irq", 32'(bus.irq), 32'h0);
        check_reg("notmr_status", A_ST, 32'h0000_0001);
        bus_write(A_CTRL, 32'h3);
`endif

        // Reset mid-stream with queued words, running timer and a concurrent write
        for (int i = 0; i < 4; i++) bus_write(A_TX, 32'hA0 + 32'(i));
        check_reg("pre_rst_status", A_ST, 32'h0000_0400 | EXP_BIT);
        check_val("pre_rst_irq", 32'(bus.irq), EXP_BIT >> 3);
        Rst = 1'b1;
        bus_write(A_TX, 32'h0000_0055);
        Rst = 1'b0;
        check_val("post_rst_valid", 32'(bus.out_valid), 32'h0);
        check_val("post_rst_data",  bus.out_data,       32'h0);
        check_val("post_rst_irq",   32'(bus.irq),       32'h0);
        check_reg("post_rst_status", A_ST,   32'h0000_0001);
        check_reg("post_rst_ctrl",   A_CTRL, 32'h0);
        check_reg("post_rst_load",   A_LD,   32'h0);
        check_reg("post_rst_count",  A_CNT,  32'h0);
        tick();
        check_val("post_rst_still_empty", 32'(bus.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
